// File: rtl/seq_pkg.sv
// Shared opcode/ALU constants, FSM state encoding and instruction layout for the
// instruction sequencer.
package seq_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned ALU_OP_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EXEC,
    WB,
    HALTED
  } seq_state_t;

  // Instruction word as it arrives from instruction memory
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
    logic [15:0]          imm;
  } instr_t;

  typedef struct packed {
    logic                is_alu;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
  } op_ctrl_t;

endpackage

// File: rtl/seq_op_decode.sv
// Opcode decoder: maps an instruction opcode to ALU control and legality.
module seq_op_decode
  import seq_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_ctrl_t            ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    ctrl_c.alu_op = ALU_ADD;
    case (opcode)
      OP_NOP: ctrl_c.is_alu = 1'b0;
      OP_ADD: begin
        ctrl_c.is_alu  = 1'b1;
        ctrl_c.alu_src = 1'b1;
        ctrl_c.alu_op  = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_c.is_alu  = 1'b1;
        ctrl_c.alu_src = 1'b1;
        ctrl_c.alu_op  = ALU_SUB;
      end
      // Unsupported opcodes retire as NOP and are flagged
      default: ctrl_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving instruction memory,
// register-file addressing and ALU control, with halt, timeout and retire count.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RET_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_valid,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [RF_ADDR_W-1:0] rf_rd_addr1,
  output logic [RF_ADDR_W-1:0] rf_rd_addr2,
  output logic [RF_ADDR_W-1:0] rf_wr_addr,
  output logic                 rf_we,
  output logic                 alu_src,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 alu_en,
  output logic                 busy,
  output logic                 err,
  output logic                 illegal,
  output logic                 retire,
  output logic [RET_W-1:0]     retired_cnt
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  instr_t              ir_q, ir_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [RET_W-1:0]    ret_q, ret_d;
  logic                halt_q, halt_d;
  logic                err_q, err_d;
  logic                retire_now;
  logic                busy_now;
  op_ctrl_t            ctrl_c;

  logic                 imem_req_d, busy_d, alu_en_d, alu_src_d, rf_we_d;
  logic                 retire_d, illegal_d, rf_live;
  logic [ALU_OP_W-1:0]  alu_op_d;
  logic [RF_ADDR_W-1:0] rd1_d, rd2_d, wr_d;

  logic unused_imm;
  assign unused_imm = ^ir_q.imm;

  // Instruction register view for the coming cycle; only WAIT loads it
  assign ir_d = (state_q == WAIT && imem_valid) ? instr_t'(imem_rdata) : ir_q;

  seq_op_decode u_dec (
    .opcode (ir_d.opcode),
    .ctrl_c (ctrl_c)
  );

  assign busy_now = (state_q != IDLE) && (state_q != HALTED);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wcnt_d     = wcnt_q;
    ret_d      = ret_q;
    halt_d     = halt_q;
    err_d      = err_q;
    retire_now = 1'b0;

    if (busy_now && halt_req) halt_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          err_d   = 1'b0;
        end
      end
      FETCH: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          state_d = DECODE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (wcnt_d == WCNT_W'(MEM_TIMEOUT)) begin
            err_d   = 1'b1;
            halt_d  = 1'b0;
            state_d = HALTED;
          end
        end
      end
      DECODE: begin
        if (ctrl_c.is_alu) state_d = EXEC;
        else               retire_now = 1'b1;
      end
      EXEC:   state_d = WB;
      WB:     retire_now = 1'b1;
      HALTED: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Instruction boundary: advance pc, count, and honour a pending halt
    if (retire_now) begin
      pc_d  = pc_q + ADDR_W'(1);
      ret_d = ret_q + RET_W'(1);
      if (halt_q || halt_req) begin
        state_d = IDLE;
        halt_d  = 1'b0;
      end else begin
        state_d = FETCH;
      end
    end

    // Registered outputs are computed for the state being entered
    rf_live    = (state_d == DECODE) || (state_d == EXEC) || (state_d == WB);
    imem_req_d = (state_d == FETCH);
    busy_d     = (state_d != IDLE) && (state_d != HALTED);
    alu_en_d   = (state_d == EXEC);
    alu_src_d  = alu_en_d & ctrl_c.alu_src;
    alu_op_d   = alu_en_d ? ctrl_c.alu_op : ALU_ADD;
    rf_we_d    = (state_d == WB);
    illegal_d  = (state_d == DECODE) && ctrl_c.illegal;
    retire_d   = ((state_d == DECODE) && !ctrl_c.is_alu) || (state_d == WB);
    rd1_d      = rf_live ? ir_d.rs1 : '0;
    rd2_d      = rf_live ? ir_d.rs2 : '0;
    wr_d       = rf_live ? ir_d.rd  : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      wcnt_q      <= '0;
      ret_q       <= '0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      alu_en      <= 1'b0;
      alu_src     <= 1'b0;
      alu_op      <= '0;
      rf_we       <= 1'b0;
      illegal     <= 1'b0;
      retire      <= 1'b0;
      rf_rd_addr1 <= '0;
      rf_rd_addr2 <= '0;
      rf_wr_addr  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      wcnt_q      <= wcnt_d;
      ret_q       <= ret_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
      imem_req    <= imem_req_d;
      busy        <= busy_d;
      alu_en      <= alu_en_d;
      alu_src     <= alu_src_d;
      alu_op      <= alu_op_d;
      rf_we       <= rf_we_d;
      illegal     <= illegal_d;
      retire      <= retire_d;
      rf_rd_addr1 <= rd1_d;
      rf_rd_addr2 <= rd2_d;
      rf_wr_addr  <= wr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign err         = err_q;
  assign retired_cnt = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, halt_req, imem_valid;
  logic [31:0] imem_rdata;
  logic        imem_req, rf_we, alu_src, alu_en, busy, err, illegal, retire;
  logic [7:0]  imem_addr;
  logic [3:0]  rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [1:0]  alu_op;
  logic [15:0] retired_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // {imem_req, busy, alu_en, alu_src, alu_op[1:0], rf_we, retire, illegal, err}
  logic [9:0] ctl;
  assign ctl = {imem_req, busy, alu_en, alu_src, alu_op, rf_we, retire, illegal, err};

  localparam logic [9:0] C_IDLE     = 10'b0_0_0_0_00_0_0_0_0;
  localparam logic [9:0] C_FETCH    = 10'b1_1_0_0_00_0_0_0_0;
  localparam logic [9:0] C_BUSY     = 10'b0_1_0_0_00_0_0_0_0;
  localparam logic [9:0] C_EXEC_ADD = 10'b0_1_1_1_00_0_0_0_0;
  localparam logic [9:0] C_EXEC_SUB = 10'b0_1_1_1_01_0_0_0_0;
  localparam logic [9:0] C_WB       = 10'b0_1_0_0_00_1_1_0_0;
  localparam logic [9:0] C_DEC_NOP  = 10'b0_1_0_0_00_0_1_0_0;
  localparam logic [9:0] C_DEC_ILL  = 10'b0_1_0_0_00_0_1_1_0;
  localparam logic [9:0] C_HALTED   = 10'b0_0_0_0_00_0_0_0_1;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_wr_addr  (rf_wr_addr),
    .rf_we       (rf_we),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .alu_en      (alu_en),
    .busy        (busy),
    .err         (err),
    .illegal     (illegal),
    .retire      (retire),
    .retired_cnt (retired_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++; if (ctl !== C_IDLE) begin miscompares++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
    vectors++; if ({imem_addr, retired_cnt} !== 24'h0) begin miscompares++; $display("FAIL reset_pc_cnt got=%h/%h exp=0/0", imem_addr, retired_cnt); end
    vectors++; if ({rf_rd_addr1, rf_rd_addr2, rf_wr_addr} !== 12'h0) begin miscompares++; $display("FAIL reset_rf got=%h exp=000", {rf_rd_addr1, rf_rd_addr2, rf_wr_addr}); end
    rst_n = 1'b1;
    tick();
    vectors++; if (ctl !== C_IDLE) begin miscompares++; $display("FAIL idle_hold got=%b exp=%b", ctl, C_IDLE); end
  endtask

  task automatic test_add();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if ({ctl, imem_addr} !== {C_FETCH, 8'd0}) begin miscompares++; $display("FAIL add_fetch got=%b/%0d exp=%b/0", ctl, imem_addr, C_FETCH); end
    tick();
    vectors++; if (ctl !== C_BUSY) begin miscompares++; $display("FAIL add_wait got=%b exp=%b", ctl, C_BUSY); end
    imem_valid = 1'b1; imem_rdata = 32'h2125_0000;
    tick();
    imem_valid = 1'b0;
    vectors++; if ({ctl, rf_rd_addr1, rf_rd_addr2} !== {C_BUSY, 8'h12}) begin miscompares++; $display("FAIL add_decode got=%b/%h exp=%b/12", ctl, {rf_rd_addr1, rf_rd_addr2}, C_BUSY); end
    tick();
    vectors++; if (ctl !== C_EXEC_ADD) begin miscompares++; $display("FAIL add_exec got=%b exp=%b", ctl, C_EXEC_ADD); end
    tick();
    vectors++; if ({ctl, rf_wr_addr, retired_cnt} !== {C_WB, 4'd5, 16'd0}) begin miscompares++; $display("FAIL add_wb got=%b/%0d/%0d exp=%b/5/0", ctl, rf_wr_addr, retired_cnt, C_WB); end
    tick();
    vectors++; if ({ctl, imem_addr, retired_cnt} !== {C_FETCH, 8'd1, 16'd1}) begin miscompares++; $display("FAIL add_next got=%b/%0d/%0d exp=%b/1/1", ctl, imem_addr, retired_cnt, C_FETCH); end
  endtask

  task automatic test_sub_nop();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h4343_0000;
    tick();
    imem_valid = 1'b0;
    vectors++; if ({rf_rd_addr1, rf_rd_addr2} !== 8'h34) begin miscompares++; $display("FAIL sub_decode got=%h exp=34", {rf_rd_addr1, rf_rd_addr2}); end
    tick();
    vectors++; if (ctl !== C_EXEC_SUB) begin miscompares++; $display("FAIL sub_exec got=%b exp=%b", ctl, C_EXEC_SUB); end
    tick();
    vectors++; if ({ctl, rf_wr_addr} !== {C_WB, 4'd3}) begin miscompares++; $display("FAIL sub_wb got=%b/%0d exp=%b/3", ctl, rf_wr_addr, C_WB); end
    tick();
    vectors++; if ({ctl, imem_addr} !== {C_FETCH, 8'd1}) begin miscompares++; $display("FAIL nop_fetch got=%b/%0d exp=%b/1", ctl, imem_addr, C_FETCH); end
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h0000_0000;
    tick();
    imem_valid = 1'b0;
    vectors++; if (ctl !== C_DEC_NOP) begin miscompares++; $display("FAIL nop_decode got=%b exp=%b", ctl, C_DEC_NOP); end
    tick();
    vectors++; if ({ctl, imem_addr, retired_cnt} !== {C_FETCH, 8'd2, 16'd2}) begin miscompares++; $display("FAIL nop_next got=%b/%0d/%0d exp=%b/2/2", ctl, imem_addr, retired_cnt, C_FETCH); end
  endtask

  task automatic test_illegal();
    tick();
    imem_valid = 1'b1; imem_rdata = 32'hF000_0000;
    tick();
    imem_valid = 1'b0;
    vectors++; if (ctl !== C_DEC_ILL) begin miscompares++; $display("FAIL ill_decode got=%b exp=%b", ctl, C_DEC_ILL); end
    tick();
    vectors++; if ({ctl, imem_addr, retired_cnt} !== {C_FETCH, 8'd3, 16'd3}) begin miscompares++; $display("FAIL ill_next got=%b/%0d/%0d exp=%b/3/3", ctl, imem_addr, retired_cnt, C_FETCH); end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 15; i++) begin
      tick();
      vectors++; if (ctl !== C_BUSY) begin miscompares++; $display("FAIL to_wait%0d got=%b exp=%b", i, ctl, C_BUSY); end
    end
    tick();
    vectors++; if ({ctl, imem_addr} !== {C_HALTED, 8'd3}) begin miscompares++; $display("FAIL to_halted got=%b/%0d exp=%b/3", ctl, imem_addr, C_HALTED); end
    imem_valid = 1'b1; imem_rdata = 32'h2125_0000;
    tick();
    imem_valid = 1'b0;
    vectors++; if (ctl !== C_HALTED) begin miscompares++; $display("FAIL to_sticky got=%b exp=%b", ctl, C_HALTED); end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if ({ctl, imem_addr} !== {C_FETCH, 8'd3}) begin miscompares++; $display("FAIL to_restart got=%b/%0d exp=%b/3", ctl, imem_addr, C_FETCH); end
  endtask

  task automatic test_halt();
    tick();
    halt_req = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h2125_0000;
    tick();
    halt_req = 1'b0; imem_valid = 1'b0;
    vectors++; if (ctl !== C_BUSY) begin miscompares++; $display("FAIL halt_decode got=%b exp=%b", ctl, C_BUSY); end
    tick();
    vectors++; if (ctl !== C_EXEC_ADD) begin miscompares++; $display("FAIL halt_exec got=%b exp=%b", ctl, C_EXEC_ADD); end
    tick();
    vectors++; if (ctl !== C_WB) begin miscompares++; $display("FAIL halt_wb got=%b exp=%b", ctl, C_WB); end
    tick();
    vectors++; if ({ctl, imem_addr, retired_cnt} !== {C_IDLE, 8'd4, 16'd4}) begin miscompares++; $display("FAIL halt_idle got=%b/%0d/%0d exp=%b/4/4", ctl, imem_addr, retired_cnt, C_IDLE); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ctl !== C_IDLE) begin miscompares++; $display("FAIL halt_stay%0d got=%b exp=%b", i, ctl, C_IDLE); end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h2125_0000;
    tick();
    imem_valid = 1'b0;
    tick();
    vectors++; if (ctl !== C_EXEC_ADD) begin miscompares++; $display("FAIL rmid_exec got=%b exp=%b", ctl, C_EXEC_ADD); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if ({ctl, imem_addr, retired_cnt} !== {C_IDLE, 8'd0, 16'd0}) begin miscompares++; $display("FAIL rmid_reset got=%b/%0d/%0d exp=%b/0/0", ctl, imem_addr, retired_cnt, C_IDLE); end
  endtask

  task automatic test_pc_wrap();
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    vectors++; if (ctl !== C_FETCH) begin miscompares++; $display("FAIL wrap_start got=%b exp=%b", ctl, C_FETCH); end
    for (int n = 0; n < 256; n++) begin
      if (n == 255) begin
        vectors++; if (imem_addr !== 8'd255) begin miscompares++; $display("FAIL wrap_pc255 got=%0d exp=255", imem_addr); end
      end
      tick();
      imem_valid = 1'b1; imem_rdata = 32'h0000_0000;
      tick();
      imem_valid = 1'b0;
      tick();
      if (n == 0) begin
        vectors++; if (ctl !== C_FETCH) begin miscompares++; $display("FAIL wrap_nohalt got=%b exp=%b", ctl, C_FETCH); end
      end
    end
    vectors++; if ({imem_addr, retired_cnt} !== {8'd0, 16'd256}) begin miscompares++; $display("FAIL wrap_pc0 got=%0d/%0d exp=0/256", imem_addr, retired_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    test_reset();
    test_add();
    test_sub_nop();
    test_illegal();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute and writeback for the ALU/register-file datapath. It drives instruction-memory requests, register-file read/write addresses and write enable, and ALU control (alu_src, alu_op, alu_en). It supports start/halt control, a memory-response timeout and a retired-instruction counter. It sits between the instruction memory and the datapath, one instance per core.

Parameters:
ADDR_W, 8, width of pc / imem_addr; pc wraps modulo 2^ADDR_W
MEM_TIMEOUT, 15, maximum WAIT cycles without imem_valid before error (>=1)
RET_W, 16, width of the retired-instruction counter; wraps

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin or resume execution from IDLE/HALTED; ignored elsewhere
halt_req  in  1  request stop at the next instruction boundary
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  ADDR_W  fetch address, equals pc
imem_valid  in  1  fetch data valid, sampled only in WAIT
imem_rdata  in  32  instruction word
rf_rd_addr1  out  4  ir[27:24]
rf_rd_addr2  out  4  ir[23:20]
rf_wr_addr  out  4  ir[19:16]
rf_we  out  1  register write enable, one cycle in WB
alu_src  out  1  1 for ADD/SUB, else 0
alu_op  out  2  2'b00 ADD / NOP / illegal, 2'b01 SUB
alu_en  out  1  one-cycle pulse in EXEC
busy  out  1  1 in every state except IDLE and HALTED
err  out  1  memory-timeout flag, sticky until start or reset
illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
retire  out  1  one-cycle pulse when an instruction completes
retired_cnt  out  RET_W  count of completed instructions

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; pc, ir, wait counter and retired_cnt = 0; halt flag and err = 0; every output = 0. Reset wins over all other inputs, in every state, including mid-instruction.
- Opcode ir[31:28]: 4'h0 NOP, 4'h2 ADD, 4'h4 SUB. All other opcodes execute as NOP and pulse illegal.
- IDLE: start=1 -> FETCH.
- FETCH (1 cycle): imem_req=1, imem_addr=pc. Clear wait counter. -> WAIT.
- WAIT: if imem_valid=1, latch ir <= imem_rdata -> DECODE. Otherwise increment the wait counter; if the counter reaches MEM_TIMEOUT, set err=1 -> HALTED.
- imem_valid outside WAIT is ignored. It is not sampled in the FETCH cycle.
- DECODE (1 cycle): rf_rd_addr1/2 and rf_wr_addr are driven from ir from DECODE through WB.
  - ADD/SUB -> EXEC.
  - NOP/illegal: retire=1, pc <= pc+1 -> boundary check.
- EXEC (1 cycle): alu_en=1, alu_src and alu_op per opcode -> WB. alu_src/alu_op are 0 in all other states.
- WB (1 cycle): rf_we=1, rf_wr_addr=ir[19:16], retire=1, pc <= pc+1 -> boundary check.
- Boundary check: if the halt flag is set -> IDLE and clear the flag; else -> FETCH.
- halt_req seen high in any busy cycle sets the sticky halt flag. halt_req in IDLE/HALTED is ignored. halt_req together with start in IDLE: start wins and the flag is not set.
- HALTED: busy=0, pc holds the faulting address. start=1 clears err -> FETCH at the same pc.
- retired_cnt increments on each retire and wraps from 2^RET_W-1 to 0. pc wraps from 2^ADDR_W-1 to 0.
- Latency from FETCH entry to retire, with imem_valid on the first WAIT cycle: ADD/SUB 5 cycles, NOP 3 cycles. Each extra WAIT cycle adds 1.

Decomposition:
- Package seq_pkg:
  - opcode constants OP_NOP=4'h0, OP_ADD=4'h2, OP_SUB=4'h4
  - alu_op constants ALU_ADD=2'b00, ALU_SUB=2'b01
  - state enum seq_state_t {IDLE, FETCH, WAIT, DECODE, EXEC, WB, HALTED}
- One combinational sub-module, seq_op_decode: opcode -> {is_alu, alu_src, alu_op, illegal}. The FSM and counters stay in instr_sequencer.

Test Plan:
- Reset mid-operation: rst_n=0 for 1 cycle while in EXEC -> next cycle state IDLE, alu_en=0, rf_we=0, pc=0, retired_cnt=0.
- ADD: pc=0, start, imem_valid one cycle after imem_req with rdata=32'h2125_0000 -> DECODE rf_rd_addr1=1, rf_rd_addr2=2; EXEC alu_en=1, alu_src=1, alu_op=00; WB rf_we=1, rf_wr_addr=5; retire 5 cycles after FETCH entry; pc=1.
- SUB then NOP: 32'h4343_0000 then 32'h0000_0000 -> alu_op=01 in EXEC, rf_wr_addr=3; NOP retires with no alu_en/rf_we; retired_cnt=2, pc=2.
- Illegal opcode 32'hF000_0000 -> illegal=1 for 1 cycle in DECODE, rf_we stays 0, retire=1, pc increments.
- Timeout (MEM_TIMEOUT=15): imem_valid held 0 -> HALTED 15 WAIT cycles after FETCH, err=1, busy=0, pc unchanged. Then start -> err=0, imem_req re-issued at the same pc.
- Halt: pulse halt_req during WAIT of an ADD -> ADD completes (rf_we=1), then IDLE with no further imem_req. Also check pc wrap 255->0 with ADDR_W=8.
